// File: rtl/fault_pkg.sv
// Shared definitions for the fault detection front end: FSM encoding,
// RV32I opcode constants and the fault-bit indices used by the classifier.
package fault_pkg;

    typedef enum logic [1:0] {
        MONITOR = 2'd0,
        FLAGGED = 2'd1,
        HOLDOFF = 2'd2
    } fd_state_e;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    localparam int FAULT_ILLEGAL = 0;
    localparam int FAULT_INVALID = 1;
    localparam int FAULT_STUCK   = 2;
    localparam int FAULT_W       = 3;

    function automatic logic is_legal_opcode(input logic [6:0] op);
        logic legal;
        case (op)
            OP_OP, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL,
            OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM, OP_FENCE: legal = 1'b1;
            default:                                       legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Control combinations that no legal decode can produce.
    function automatic logic is_invalid_ctrl(input logic [6:0] op,
                                             input logic       rw,
                                             input logic       mw,
                                             input logic       mr,
                                             input logic       br);
        return (rw & mw) | (mr & mw) | (br & mw) | (br & rw & (op == OP_BRANCH));
    endfunction

endpackage

// File: rtl/fault_detector_stuck_at_monitor.sv
// Stuck-at watcher: captures a reference probe value and counts consecutive
// equal comparisons; raises stuck_raw on the comparison that reaches STUCK_LIMIT.
module stuck_at_monitor #(
    parameter int STUCK_LIMIT = 16,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        track,
    input  logic        clear,
    input  logic [31:0] probe_data,
    output logic        stuck_raw
);
    import fault_pkg::*;

    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(STUCK_LIMIT);
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STUCK_LIMIT - 1);

    logic             have_ref_q, have_ref_d;
    logic [31:0]      last_probe_q, last_probe_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic             equal;

    always_ff @(posedge clk) begin
        if (reset) begin
            have_ref_q   <= 1'b0;
            last_probe_q <= '0;
            run_cnt_q    <= '0;
        end else begin
            have_ref_q   <= have_ref_d;
            last_probe_q <= last_probe_d;
            run_cnt_q    <= run_cnt_d;
        end
    end

    always_comb begin
        equal        = (probe_data == last_probe_q);
        stuck_raw    = track & have_ref_q & equal & (run_cnt_q == LIMIT_M1);
        have_ref_d   = have_ref_q;
        last_probe_d = last_probe_q;
        run_cnt_d    = run_cnt_q;
        if (clear) begin
            have_ref_d = 1'b0;
            run_cnt_d  = '0;
        end else if (track) begin
            if (!have_ref_q) begin
                last_probe_d = probe_data;
                have_ref_d   = 1'b1;
                run_cnt_d    = '0;
            end else if (equal) begin
                if (run_cnt_q < LIMIT) begin
                    run_cnt_d = run_cnt_q + CNT_W'(1);
                end
            end else begin
                run_cnt_d    = '0;
                last_probe_d = probe_data;
            end
        end
    end

endmodule

// File: rtl/fault_detector.sv
// Fault detection front end: flags illegal opcodes, bad control bundles and a
// stuck datapath probe. Optional inject port enabled by FAULT_DETECTOR_INJECT_EN.
module fault_detector
    import fault_pkg::*;
#(
    parameter int STUCK_LIMIT    = 16,
    parameter int CNT_W          = 8,
    parameter int HOLDOFF_CYCLES = 4,
    parameter int HOLD_W         = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [6:0]  opcode,
    input  logic        reg_write,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic        branch,
    input  logic [31:0] probe_data,
    input  logic        fault_clear,
`ifdef FAULT_DETECTOR_INJECT_EN
    input  logic [2:0]  inject,
`endif
    output logic        illegal_opcode,
    output logic        invalid_control,
    output logic        stuck_at_fault,
    output logic        detector_busy,
    output logic [15:0] fault_count
);

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF_CYCLES);

    fd_state_e           state_q, state_d;
    logic [FAULT_W-1:0]  flags_q, flags_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [15:0]         count_q, count_d;

    logic                in_monitor;
    logic                stuck_clear;
    logic                stuck_raw;
    logic [FAULT_W-1:0]  raw_hw;
    logic [FAULT_W-1:0]  raw;
    logic                detect;

    assign in_monitor  = (state_q == MONITOR);
    assign stuck_clear = (state_q == FLAGGED) & fault_clear;

    stuck_at_monitor #(
        .STUCK_LIMIT (STUCK_LIMIT),
        .CNT_W       (CNT_W)
    ) u_stuck (
        .clk        (clk),
        .reset      (reset),
        .track      (in_monitor & instr_valid),
        .clear      (stuck_clear),
        .probe_data (probe_data),
        .stuck_raw  (stuck_raw)
    );

    always_comb begin
        raw_hw                = '0;
        raw_hw[FAULT_ILLEGAL] = instr_valid & ~is_legal_opcode(opcode);
        raw_hw[FAULT_INVALID] = instr_valid &
                                is_invalid_ctrl(opcode, reg_write, mem_write, mem_read, branch);
        raw_hw[FAULT_STUCK]   = stuck_raw;
`ifdef FAULT_DETECTOR_INJECT_EN
        raw = in_monitor ? (raw_hw | inject) : '0;
`else
        raw = in_monitor ? raw_hw : '0;
`endif
        detect = |raw;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MONITOR;
            flags_q <= '0;
            hold_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            hold_q  <= hold_d;
            count_q <= count_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        flags_d = flags_q;
        hold_d  = hold_q;
        count_d = count_q;
        case (state_q)
            MONITOR: begin
                if (detect) begin
                    state_d = FLAGGED;
                    flags_d = raw;
                    count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
                end
            end
            FLAGGED: begin
                if (fault_clear) begin
                    flags_d = '0;
                    hold_d  = HOLD_LOAD;
                    state_d = (HOLDOFF_CYCLES == 0) ? MONITOR : HOLDOFF;
                end
            end
            HOLDOFF: begin
                hold_d = hold_q - HOLD_W'(1);
                if (hold_q <= HOLD_W'(1)) begin
                    state_d = MONITOR;
                end
            end
            default: begin
                state_d = MONITOR;
            end
        endcase
    end

    // Outputs
    always_comb begin
        illegal_opcode  = flags_q[FAULT_ILLEGAL];
        invalid_control = flags_q[FAULT_INVALID];
        stuck_at_fault  = flags_q[FAULT_STUCK];
        detector_busy   = (state_q != MONITOR);
        fault_count     = count_q;
    end

endmodule

// File: tb/tb_fault_detector.sv
// Scoreboard bench for fault_detector: directed steps push hand-computed
// expectations; a monitor pops one entry per clock and compares all outputs.
module tb_fault_detector;
    import fault_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [6:0]  opcode;
    logic        reg_write, mem_write, mem_read, branch;
    logic [31:0] probe_data;
    logic        fault_clear;
`ifdef FAULT_DETECTOR_INJECT_EN
    logic [2:0]  inject = 3'b000;
`endif
    logic        illegal_opcode, invalid_control, stuck_at_fault, detector_busy;
    logic [15:0] fault_count;

    always #5 clk = ~clk;

    fault_detector dut (
        .clk             (clk),
        .reset           (reset),
        .instr_valid     (instr_valid),
        .opcode          (opcode),
        .reg_write       (reg_write),
        .mem_write       (mem_write),
        .mem_read        (mem_read),
        .branch          (branch),
        .probe_data      (probe_data),
        .fault_clear     (fault_clear),
`ifdef FAULT_DETECTOR_INJECT_EN
        .inject          (inject),
`endif
        .illegal_opcode  (illegal_opcode),
        .invalid_control (invalid_control),
        .stuck_at_fault  (stuck_at_fault),
        .detector_busy   (detector_busy),
        .fault_count     (fault_count)
    );

    typedef struct {
        string       name;
        logic        ill;
        logic        inv;
        logic        stk;
        logic        busy;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   seq     = 0;

    function automatic logic [31:0] np();
        seq++;
        return 32'h1000_0000 + 32'(seq);
    endfunction

    task automatic chk(input string name, input string field,
                       input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h expected %0h", name, field, act, exp);
        end
    endtask

    // Drive one cycle of stimulus and queue the outputs expected after the edge.
    task automatic step(input string name, input logic v, input logic [6:0] op,
                        input logic rw, input logic mw, input logic mr, input logic br,
                        input logic [31:0] pr, input logic clr, input logic rst,
                        input logic e_ill, input logic e_inv, input logic e_stk,
                        input logic e_busy, input logic [15:0] e_cnt);
        exp_t e;
        @(negedge clk);
        reset       = rst;
        instr_valid = v;
        opcode      = op;
        reg_write   = rw;
        mem_write   = mw;
        mem_read    = mr;
        branch      = br;
        probe_data  = pr;
        fault_clear = clr;
        e.name = name;
        e.ill  = e_ill;
        e.inv  = e_inv;
        e.stk  = e_stk;
        e.busy = e_busy;
        e.cnt  = e_cnt;
        sb_q.push_back(e);
    endtask

    task automatic idle(input string name, input logic e_ill, input logic e_inv,
                        input logic e_stk, input logic e_busy, input logic [15:0] e_cnt);
        step(name, 1'b0, OP_IMM, 1'b0, 1'b0, 1'b0, 1'b0, np(), 1'b0, 1'b0,
             e_ill, e_inv, e_stk, e_busy, e_cnt);
    endtask

    // Clear from FLAGGED: one clear cycle plus three hold-off cycles stay busy.
    task automatic clear_and_wait(input logic [15:0] c);
        step("clear", 1'b0, OP_IMM, 1'b0, 1'b0, 1'b0, 1'b0, np(), 1'b1, 1'b0,
             1'b0, 1'b0, 1'b0, 1'b1, c);
        repeat (3) idle("holdoff", 1'b0, 1'b0, 1'b0, 1'b1, c);
        idle("resume", 1'b0, 1'b0, 1'b0, 1'b0, c);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                $display("[TB] %s: ill=%b inv=%b stk=%b busy=%b cnt=%0h", e.name,
                         illegal_opcode, invalid_control, stuck_at_fault,
                         detector_busy, fault_count);
                chk(e.name, "illegal_opcode", 16'(illegal_opcode), 16'(e.ill));
                chk(e.name, "invalid_control", 16'(invalid_control), 16'(e.inv));
                chk(e.name, "stuck_at_fault", 16'(stuck_at_fault), 16'(e.stk));
                chk(e.name, "detector_busy", 16'(detector_busy), 16'(e.busy));
                chk(e.name, "fault_count", fault_count, e.cnt);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        reset = 1'b1; instr_valid = 1'b0; opcode = OP_IMM; reg_write = 1'b0;
        mem_write = 1'b0; mem_read = 1'b0; branch = 1'b0; probe_data = '0;
        fault_clear = 1'b0;

        repeat (2) step("reset", 1'b0, OP_IMM, 0, 0, 0, 0, np(), 1'b0, 1'b1, 0, 0, 0, 0, 16'd0);

        // Illegal opcode latches and holds without fault_clear
        step("t1_illegal", 1'b1, 7'b0000000, 0, 0, 0, 0, np(), 1'b0, 1'b0, 1, 0, 0, 1, 16'd1);
        repeat (10) idle("t1_hold", 1, 0, 0, 1, 16'd1);

        // Clear, hold-off ignores illegal opcodes, then detection resumes
        step("t4_clear", 1'b0, OP_IMM, 0, 0, 0, 0, np(), 1'b1, 1'b0, 0, 0, 0, 1, 16'd1);
        repeat (3) step("t4_holdoff", 1'b1, 7'b1111111, 0, 0, 0, 0, np(), 1'b0, 1'b0,
                        0, 0, 0, 1, 16'd1);
        step("t4_exit", 1'b1, 7'b1111111, 0, 0, 0, 0, np(), 1'b0, 1'b0, 0, 0, 0, 0, 16'd1);
        step("t4_after", 1'b1, 7'b1111111, 0, 0, 0, 0, np(), 1'b0, 1'b0, 1, 0, 0, 1, 16'd2);
        clear_and_wait(16'd2);

        // Invalid control combinations, gated by instr_valid
        step("t2_gated", 1'b0, OP_STORE, 1, 1, 0, 0, np(), 1'b0, 1'b0, 0, 0, 0, 0, 16'd2);
        step("t2_rw_mw", 1'b1, OP_STORE, 1, 1, 0, 0, np(), 1'b0, 1'b0, 0, 1, 0, 1, 16'd3);
        clear_and_wait(16'd3);
        step("t2_mr_mw", 1'b1, OP_LOAD, 0, 1, 1, 0, np(), 1'b0, 1'b0, 0, 1, 0, 1, 16'd4);
        clear_and_wait(16'd4);
        step("t2_br_rw", 1'b1, OP_BRANCH, 1, 0, 0, 1, np(), 1'b0, 1'b0, 0, 1, 0, 1, 16'd5);
        clear_and_wait(16'd5);
        step("t2_branch_ok", 1'b1, OP_BRANCH, 0, 0, 0, 1, np(), 1'b0, 1'b0, 0, 0, 0, 0, 16'd5);
        step("clear_in_mon", 1'b1, OP_JAL, 1, 0, 0, 0, np(), 1'b1, 1'b0, 0, 0, 0, 0, 16'd5);

        // Two flags in one event count once; detection beats coincident clear
        step("t5_both", 1'b1, 7'b0000000, 1, 1, 0, 0, np(), 1'b1, 1'b0, 1, 1, 0, 1, 16'd6);
        idle("t5_hold", 1, 1, 0, 1, 16'd6);
        step("t5_reset", 1'b0, OP_IMM, 0, 0, 0, 0, np(), 1'b0, 1'b1, 0, 0, 0, 0, 16'd0);

        // Stuck probe: 17 equal-probe instructions flag on the 17th
        for (int k = 1; k <= 17; k++) begin
            if (k < 17)
                step("t3_run", 1'b1, OP_IMM, 0, 0, 0, 0, 32'hDEADBEEF, 1'b0, 1'b0,
                     0, 0, 0, 0, 16'd0);
            else
                step("t3_stuck", 1'b1, OP_IMM, 0, 0, 0, 0, 32'hDEADBEEF, 1'b0, 1'b0,
                     0, 0, 1, 1, 16'd1);
        end
        clear_and_wait(16'd1);
        for (int k = 1; k <= 17; k++) begin
            step("t3_broken", 1'b1, OP_IMM, 0, 0, 0, 0,
                 (k == 16) ? 32'h12345678 : 32'hDEADBEEF, 1'b0, 1'b0, 0, 0, 0, 0, 16'd1);
        end

        // Counter saturation: preload near the top, then two more events
        idle("t6_preload", 0, 0, 0, 0, 16'hFFFE);
        force dut.count_q = 16'hFFFE;
        @(negedge clk);
        release dut.count_q;
        step("t6_to_max", 1'b1, 7'b0000000, 0, 0, 0, 0, np(), 1'b0, 1'b0, 1, 0, 0, 1, 16'hFFFF);
        clear_and_wait(16'hFFFF);
        step("t6_sat", 1'b1, 7'b0000000, 0, 0, 0, 0, np(), 1'b0, 1'b0, 1, 0, 0, 1, 16'hFFFF);

        repeat (3) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
